// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: paces the 8N1 receiver with a 16x-baud sample tick and
// assembles its byte stream into SOF/CMD/LEN/payload/XOR-checksum frames,
// holding each good frame for the consumer until it is acknowledged.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// WAIT_SOF | idle, discarding bytes until the start-of-frame marker
// GET_CMD  | next byte is the command
// GET_LEN  | next byte is the payload length (checked against buffer depth)
// GET_PAY  | storing payload bytes into the buffer
// GET_CHK  | next byte is compared with the running XOR of CMD, LEN, payload
// HOLD     | frame presented on frame_valid; buffer frozen until frame_ack
module uart_rx_frame_ctrl #(
  parameter int         CLK_FREQ       = 50_000_000,
  parameter int         BAUD           = 9600,
  parameter int         MAX_PAYLOAD    = 16,
  parameter int         TIMEOUT_CYCLES = 5_000_000,
  parameter logic [7:0] SOF_BYTE       = 8'hAA,
  localparam int        LEN_W          = $clog2(MAX_PAYLOAD + 1),
  localparam int        ADDR_W         = $clog2(MAX_PAYLOAD)
) (
  input  logic              clk_50MHz,
  input  logic              reset,
  output logic              sample_tick,
  input  logic              rx_data_ready,
  input  logic [7:0]        rx_data,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic [7:0]        frame_cmd,
  output logic [LEN_W-1:0]  frame_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              frame_error,
  output logic [1:0]        err_code,
  output logic              overrun
);

  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] S_WAIT_SOF = 3'd0;
  localparam logic [2:0] S_GET_CMD  = 3'd1;
  localparam logic [2:0] S_GET_LEN  = 3'd2;
  localparam logic [2:0] S_GET_PAY  = 3'd3;
  localparam logic [2:0] S_GET_CHK  = 3'd4;
  localparam logic [2:0] S_HOLD     = 3'd5;

  localparam logic [1:0] ERR_CHK = 2'b01;
  localparam logic [1:0] ERR_LEN = 2'b10;
  localparam logic [1:0] ERR_TO  = 2'b11;

  logic [DIV_W-1:0]  r_div;
  logic [TO_W-1:0]   r_to_cnt;
  logic [2:0]        r_state;
  logic [7:0]        r_chk;
  logic [7:0]        r_cmd;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_idx;
  logic [7:0]        r_buf [MAX_PAYLOAD];
  logic              r_err;
  logic [1:0]        r_err_code;
  logic              r_overrun;

  logic w_tick;
  logic w_in_frame;
  logic w_timeout;
  logic w_last_pay;

  assign w_tick     = (r_div == DIV_W'(DIV - 1));
  assign w_in_frame = (r_state == S_GET_CMD) || (r_state == S_GET_LEN) ||
                      (r_state == S_GET_PAY) || (r_state == S_GET_CHK);
  // A timeout takes priority over a byte arriving in the same cycle.
  assign w_timeout  = w_in_frame && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_last_pay = ((LEN_W'(r_idx) + LEN_W'(1)) == r_len);

  assign sample_tick = w_tick;
  assign frame_valid = (r_state == S_HOLD);
  assign frame_cmd   = r_cmd;
  assign frame_len   = r_len;
  assign rd_data     = r_buf[rd_addr];
  assign frame_error = r_err;
  assign err_code    = r_err_code;
  assign overrun     = r_overrun;

  // Free-running baud divider; wraps after the tick cycle.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Inter-byte idle counter, only running while a frame is being assembled.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (!w_in_frame || w_timeout || rx_data_ready) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // Payload buffer write; only the payload state stores bytes.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_PAYLOAD; i++) r_buf[i] <= 8'h00;
    end else if ((r_state == S_GET_PAY) && rx_data_ready && !w_timeout) begin
      r_buf[r_idx] <= rx_data;
    end
  end

  // Frame parser: state, header fields, checksum, error pulse and overrun flag.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      r_state    <= S_WAIT_SOF;
      r_chk      <= 8'h00;
      r_cmd      <= 8'h00;
      r_len      <= '0;
      r_idx      <= '0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
      r_overrun  <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_timeout) begin
        r_state    <= S_WAIT_SOF;
        r_err      <= 1'b1;
        r_err_code <= ERR_TO;
      end else begin
        case (r_state)
          S_WAIT_SOF: begin
            if (rx_data_ready && (rx_data == SOF_BYTE)) begin
              r_chk   <= 8'h00;
              r_state <= S_GET_CMD;
            end
          end
          S_GET_CMD: begin
            if (rx_data_ready) begin
              r_cmd   <= rx_data;
              r_chk   <= rx_data;
              r_state <= S_GET_LEN;
            end
          end
          S_GET_LEN: begin
            if (rx_data_ready) begin
              if (rx_data > 8'(MAX_PAYLOAD)) begin
                r_err      <= 1'b1;
                r_err_code <= ERR_LEN;
                r_state    <= S_WAIT_SOF;
              end else begin
                r_len   <= rx_data[LEN_W-1:0];
                r_chk   <= r_chk ^ rx_data;
                r_idx   <= '0;
                r_state <= (rx_data == 8'h00) ? S_GET_CHK : S_GET_PAY;
              end
            end
          end
          S_GET_PAY: begin
            if (rx_data_ready) begin
              r_chk <= r_chk ^ rx_data;
              r_idx <= r_idx + ADDR_W'(1);
              if (w_last_pay) r_state <= S_GET_CHK;
            end
          end
          S_GET_CHK: begin
            if (rx_data_ready) begin
              if (rx_data == r_chk) begin
                r_state <= S_HOLD;
              end else begin
                r_err      <= 1'b1;
                r_err_code <= ERR_CHK;
                r_state    <= S_WAIT_SOF;
              end
            end
          end
          S_HOLD: begin
            if (frame_ack) begin
              r_overrun <= 1'b0;
              r_state   <= S_WAIT_SOF;
            end else if (rx_data_ready) begin
              r_overrun <= 1'b1;
            end
          end
          default: r_state <= S_WAIT_SOF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_rx_frame_ctrl: stimulus pushes expected frames and
// errors into a queue, a monitor pops and compares whenever the DUT reports.
module tb_uart_rx_frame_ctrl;

  localparam int TO = 200;

  logic       clk_50MHz = 1'b0;
  logic       reset;
  logic       sample_tick;
  logic       rx_data_ready;
  logic [7:0] rx_data;
  logic       frame_valid;
  logic       frame_ack;
  logic [7:0] frame_cmd;
  logic [4:0] frame_len;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_error;
  logic [1:0] err_code;
  logic       overrun;

  uart_rx_frame_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .sample_tick(sample_tick),
    .rx_data_ready(rx_data_ready), .rx_data(rx_data),
    .frame_valid(frame_valid), .frame_ack(frame_ack),
    .frame_cmd(frame_cmd), .frame_len(frame_len),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_error(frame_error), .err_code(err_code), .overrun(overrun)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  typedef struct {
    bit           is_err;
    logic [1:0]   code;
    logic [7:0]   cmd;
    int           len;
    logic [127:0] pay;
    longint       cyc;
  } exp_t;

  exp_t   exp_q[$];
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  longint last_cyc = 0;
  bit     hold_ack = 1'b0;
  bit     seen = 1'b0;

  always @(posedge clk_50MHz) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input bit is_err, input logic [1:0] code, input logic [7:0] cmd,
                          input int len, input logic [127:0] pay, input longint c);
    exp_t e;
    e.is_err = is_err; e.code = code; e.cmd = cmd; e.len = len; e.pay = pay; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_50MHz); #1;
    rx_data_ready = 1'b1;
    rx_data = b;
    @(posedge clk_50MHz); #1;
    rx_data_ready = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_50MHz);
    #1;
  endtask

  // Reference model: checksum is the XOR of CMD, LEN and payload; LEN above 16
  // aborts right after the LEN byte.
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len_b,
                            input logic [127:0] pay, input logic [7:0] corrupt,
                            input int maxgap);
    logic [7:0] x;
    send_byte(8'hAA); idle($urandom_range(0, maxgap));
    send_byte(cmd);   idle($urandom_range(0, maxgap));
    send_byte(len_b);
    if (len_b > 8'd16) begin
      push_exp(1'b1, 2'b10, 8'h00, 0, '0, last_cyc);
      return;
    end
    x = cmd ^ len_b;
    for (int i = 0; i < int'(len_b); i++) begin
      idle($urandom_range(0, maxgap));
      send_byte(pay[i*8 +: 8]);
      x = x ^ pay[i*8 +: 8];
    end
    idle($urandom_range(0, maxgap));
    send_byte(x ^ corrupt);
    if (corrupt != 8'h00) push_exp(1'b1, 2'b01, 8'h00, 0, '0, last_cyc);
    else                  push_exp(1'b0, 2'b00, cmd, int'(len_b), pay, last_cyc);
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((exp_q.size() != 0 || frame_valid) && n < 600) begin
      @(posedge clk_50MHz); #1;
      n++;
    end
    if (n >= 600) begin
      errors++;
      $display("FAIL quiet_timeout actual=%0d pending expected=0", exp_q.size());
    end
  endtask

  // Monitor: compares every error pulse and every newly held frame, then acks.
  initial begin
    exp_t e;
    frame_ack = 1'b0;
    rd_addr = 4'd0;
    forever begin
      @(negedge clk_50MHz);
      if (!reset) begin
        seen = 1'b0;
      end else begin
        if (frame_error) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_error actual=%0d expected=none", err_code);
          end else begin
            e = exp_q.pop_front();
            check("kind_is_error", 32'(e.is_err), 32'(1));
            check("err_code", 32'(err_code), 32'(e.code));
            check("err_latency", 32'(cyc), 32'(e.cyc));
          end
        end
        if (frame_valid && !seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame actual=%0h expected=none", frame_cmd);
          end else begin
            e = exp_q.pop_front();
            check("kind_is_frame", 32'(e.is_err), 32'(0));
            check("frame_cmd", 32'(frame_cmd), 32'(e.cmd));
            check("frame_len", 32'(frame_len), 32'(e.len));
            check("valid_latency", 32'(cyc), 32'(e.cyc));
            for (int i = 0; i < e.len; i++) begin
              rd_addr = 4'(i);
              #0.5;
              check("payload", 32'(rd_data), 32'(e.pay[i*8 +: 8]));
            end
          end
        end
        if (frame_valid && seen && !hold_ack) begin
          frame_ack = 1'b1;
          @(posedge clk_50MHz); #1;
          frame_ack = 1'b0;
        end
        if (!frame_valid) seen = 1'b0;
      end
    end
  end

  initial begin
    longint t0;
    int     n;
    logic [127:0] pay;
    reset = 1'b0;
    rx_data_ready = 1'b0;
    rx_data = 8'h00;
    #35;
    check("rst_valid", 32'(frame_valid), 32'(0));
    check("rst_error", 32'(frame_error), 32'(0));
    check("rst_code", 32'(err_code), 32'(0));
    check("rst_overrun", 32'(overrun), 32'(0));
    check("rst_tick", 32'(sample_tick), 32'(0));
    @(negedge clk_50MHz);
    reset = 1'b1;

    // Sample tick: one-cycle pulse every 325 clocks.
    n = 0;
    while (!sample_tick && n < 400) begin @(negedge clk_50MHz); n++; end
    check("tick_seen", 32'(sample_tick), 32'(1));
    for (int p = 0; p < 2; p++) begin
      t0 = cyc;
      @(negedge clk_50MHz);
      check("tick_width", 32'(sample_tick), 32'(0));
      n = 0;
      while (!sample_tick && n < 400) begin @(negedge clk_50MHz); n++; end
      check("tick_period", 32'(cyc - t0), 32'(325));
    end

    // Good frame AA 10 02 12 34 34.
    send_frame(8'h10, 8'h02, 128'h3412, 8'h00, 0);
    wait_quiet();
    // Bad checksum 35.
    send_frame(8'h10, 8'h02, 128'h3412, 8'h01, 0);
    wait_quiet();
    check("chk_err_no_valid", 32'(frame_valid), 32'(0));
    // Leading junk 55, zero-length frame.
    send_byte(8'h55);
    send_frame(8'h05, 8'h00, '0, 8'h00, 0);
    wait_quiet();
    // Length 17 rejected, then a normal frame.
    send_frame(8'h01, 8'h11, '0, 8'h00, 0);
    wait_quiet();
    send_frame(8'h20, 8'h01, 128'h7E, 8'h00, 1);
    wait_quiet();
    // Full-depth frame.
    send_frame(8'h3C, 8'h10, {$urandom, $urandom, $urandom, $urandom}, 8'h00, 1);
    wait_quiet();

    // Timeout after CMD; byte injected on the timeout cycle must be dropped.
    send_byte(8'hAA);
    send_byte(8'h10);
    push_exp(1'b1, 2'b11, 8'h00, 0, '0, last_cyc + TO);
    repeat (TO - 1) @(posedge clk_50MHz);
    #1;
    rx_data_ready = 1'b1;
    rx_data = 8'hAA;
    @(posedge clk_50MHz); #1;
    rx_data_ready = 1'b0;
    send_byte(8'h33); send_byte(8'h00); send_byte(8'h33);
    send_frame(8'h44, 8'h00, '0, 8'h00, 0);
    wait_quiet();

    // Overrun while a frame is held; ack clears it.
    hold_ack = 1'b1;
    send_frame(8'h10, 8'h02, 128'h3412, 8'h00, 0);
    n = 0;
    while (!frame_valid && n < 100) begin @(posedge clk_50MHz); #1; n++; end
    check("hold_valid", 32'(frame_valid), 32'(1));
    check("hold_overrun_clear", 32'(overrun), 32'(0));
    send_byte(8'h55);
    @(negedge clk_50MHz);
    check("overrun_set", 32'(overrun), 32'(1));
    check("hold_cmd_frozen", 32'(frame_cmd), 32'(8'h10));
    check("hold_len_frozen", 32'(frame_len), 32'(2));
    send_byte(8'hAA);
    hold_ack = 1'b0;
    wait_quiet();
    @(negedge clk_50MHz);
    check("overrun_cleared", 32'(overrun), 32'(0));

    // Reset mid-payload clears everything asynchronously.
    send_byte(8'hAA); send_byte(8'h10); send_byte(8'h05);
    send_byte(8'h11); send_byte(8'h22);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(frame_valid), 32'(0));
    check("arst_error", 32'(frame_error), 32'(0));
    check("arst_code", 32'(err_code), 32'(0));
    check("arst_cmd", 32'(frame_cmd), 32'(0));
    check("arst_len", 32'(frame_len), 32'(0));
    check("arst_overrun", 32'(overrun), 32'(0));
    check("arst_tick", 32'(sample_tick), 32'(0));
    check("arst_rd_data", 32'(rd_data), 32'(0));
    idle(3);
    @(negedge clk_50MHz);
    reset = 1'b1;

    // Randomized frames against the reference model.
    for (int f = 0; f < 25; f++) begin
      int   kind;
      int   junk;
      logic [7:0] jb;
      junk = $urandom_range(0, 2);
      for (int j = 0; j < junk; j++) begin
        jb = 8'($urandom);
        if (jb == 8'hAA) jb = 8'h55;
        send_byte(jb);
      end
      pay = {$urandom, $urandom, $urandom, $urandom};
      kind = $urandom_range(0, 9);
      if (kind < 6)
        send_frame(8'($urandom), 8'($urandom_range(0, 16)), pay, 8'h00, 3);
      else if (kind < 8)
        send_frame(8'($urandom), 8'($urandom_range(0, 16)), pay, 8'($urandom_range(1, 255)), 3);
      else
        send_frame(8'($urandom), 8'($urandom_range(17, 255)), pay, 8'h00, 3);
      wait_quiet();
    end

    idle(5);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "bench time limit");
  end

endmodule
